vram_port_arbiter: RTL and testbench

- Single-clock controller that owns both ports of the 1024x8 text VRAM simple-dual-port block RAM.
- Write port: shared between CPU stores and a built-in clear/fill engine.
- Read port: shared between the LCD character fetcher (fixed priority, hard deadline) and CPU loads.
- Sits between the CPU bus decoder / LCD timing generator and the VRAM macro; the macro's clka/clkb are both tied to clk.

---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_clear_engine.sv | 78 +++++++
 rtl/vram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_vram_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// ----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the text-VRAM port arbiter and its clear engine.
//   ADDR_W_DEF / DATA_W_DEF : default VRAM address and data widths
//   TEXT_COLS / TEXT_ROWS   : visible text grid geometry
//   CLEAR_LAST_DEF          : last cell address touched by a clear/fill
//   wr_state_t              : write-side FSM states
// ----------------------------------------------------------------------------
package vram_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 8;
    localparam int TEXT_COLS      = 60;
    localparam int TEXT_ROWS      = 17;
    localparam int CLEAR_LAST_DEF = TEXT_COLS * TEXT_ROWS - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wr_state_t;

endpackage

// File: rtl/vram_clear_engine.sv
// ----------------------------------------------------------------------------
// vram_clear_engine
// Walks the text area of the VRAM writing one fill byte per cycle.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   clr_start    : start pulse, honoured only while idle
//   clr_value    : fill byte, captured together with clr_start
//   busy         : registered, high while the fill owns the write port
//   done         : registered one-cycle pulse in the first cycle after the
//                  final write
//   ptr          : address being written this cycle while busy
//   fill_value   : latched fill byte
// ----------------------------------------------------------------------------
module vram_clear_engine
    import vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CLEAR_LAST = CLEAR_LAST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ptr,
    output logic [DATA_W-1:0] fill_value
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_LAST);

    wr_state_t state;

    // Single-process FSM. busy mirrors the CLEAR state but is registered
    // separately so the top-level muxes read a flop, not a decode.
    // A start request arriving while already clearing is simply dropped,
    // and the fill byte is never re-sampled mid-fill. done is cleared every
    // cycle and only raised on the edge that leaves CLEAR, which makes it a
    // single-cycle pulse; a reset mid-fill takes the reset branch and so
    // never produces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ptr        <= '0;
            fill_value <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        ptr        <= '0;
                        fill_value <= clr_value;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// ----------------------------------------------------------------------------
// vram_port_arbiter
// Owns both ports of the simple-dual-port text VRAM.
// Ports:
//   clk, reset                          : system clock, sync active-high reset
//   cpu_we/cpu_waddr/cpu_wdata/
//   cpu_wready                          : CPU store channel
//   cpu_re/cpu_raddr/cpu_rready/
//   cpu_rvalid/cpu_rdata                : CPU load channel
//   disp_req/disp_addr/disp_rvalid/
//   disp_rdata                          : LCD character fetch, always granted
//   clr_start/clr_value/clr_busy/
//   clr_done                            : clear/fill engine control
//   vram_cea/vram_ada/vram_din          : VRAM write port
//   vram_ceb/vram_oce/vram_adb/
//   vram_dout                           : VRAM read port (1-cycle latency)
// ----------------------------------------------------------------------------
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CLEAR_LAST = CLEAR_LAST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_wready,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_raddr,
    output logic              cpu_rready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              vram_cea,
    output logic [ADDR_W-1:0] vram_ada,
    output logic [DATA_W-1:0] vram_din,
    output logic              vram_ceb,
    output logic              vram_oce,
    output logic [ADDR_W-1:0] vram_adb,
    input  logic [DATA_W-1:0] vram_dout
);

    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] clr_fill;
    logic              disp_grant;
    logic              cpu_grant;

    vram_clear_engine #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CLEAR_LAST (CLEAR_LAST)
    ) u_clear (
        .clk        (clk),
        .reset      (reset),
        .clr_start  (clr_start),
        .clr_value  (clr_value),
        .busy       (clr_busy),
        .done       (clr_done),
        .ptr        (clr_ptr),
        .fill_value (clr_fill)
    );

    // Write port: the fill engine owns it outright while busy, otherwise the
    // CPU store passes straight through. A store issued in the same cycle as
    // clr_start still lands, because the engine only takes over next cycle.
    // Enables are held low during reset so a reset mid-fill stops writing
    // immediately.
    always_comb begin
        cpu_wready = 1'b0;
        vram_cea   = 1'b0;
        vram_ada   = cpu_waddr;
        vram_din   = cpu_wdata;
        if (clr_busy) begin
            vram_ada = clr_ptr;
            vram_din = clr_fill;
        end
        if (!reset) begin
            cpu_wready = !clr_busy;
            vram_cea   = clr_busy | cpu_we;
        end
    end

    // Read port: the display has a hard deadline so it always wins; the CPU
    // gets the port only in cycles without a display fetch and must hold its
    // request until cpu_rready is seen.
    always_comb begin
        disp_grant = !reset && disp_req;
        cpu_grant  = !reset && !disp_req && cpu_re;
        cpu_rready = !reset && !disp_req;
        vram_ceb   = disp_grant | cpu_grant;
        vram_adb   = disp_req ? disp_addr : cpu_raddr;
    end

    // Read tags: the RAM returns data one cycle after the grant, so each
    // grant is delayed by one flop to mark whose data is on vram_dout.
    // The grants are mutually exclusive, so the tags are too.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_rvalid <= 1'b0;
            cpu_rvalid  <= 1'b0;
        end else begin
            disp_rvalid <= disp_grant;
            cpu_rvalid  <= cpu_grant;
        end
    end

    assign vram_oce   = 1'b1;
    assign cpu_rdata  = vram_dout;
    assign disp_rdata = vram_dout;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_port_arbiter
// Drives vram_port_arbiter against a behavioural VRAM and compares every
// cycle against a reference model of the expected memory contents, fill
// progress and read-return bookkeeping.
// ----------------------------------------------------------------------------
module tb_vram_port_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int LAST  = 1019;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_we;
    logic [AW-1:0] cpu_waddr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_wready;
    logic          cpu_re;
    logic [AW-1:0] cpu_raddr;
    logic          cpu_rready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          clr_start;
    logic [DW-1:0] clr_value;
    logic          clr_busy;
    logic          clr_done;
    logic          vram_cea;
    logic [AW-1:0] vram_ada;
    logic [DW-1:0] vram_din;
    logic          vram_ceb;
    logic          vram_oce;
    logic [AW-1:0] vram_adb;
    logic [DW-1:0] vram_dout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .CLEAR_LAST (LAST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_we      (cpu_we),
        .cpu_waddr   (cpu_waddr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wready  (cpu_wready),
        .cpu_re      (cpu_re),
        .cpu_raddr   (cpu_raddr),
        .cpu_rready  (cpu_rready),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .clr_start   (clr_start),
        .clr_value   (clr_value),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .vram_cea    (vram_cea),
        .vram_ada    (vram_ada),
        .vram_din    (vram_din),
        .vram_ceb    (vram_ceb),
        .vram_oce    (vram_oce),
        .vram_adb    (vram_adb),
        .vram_dout   (vram_dout)
    );

    // Behavioural simple-dual-port RAM: write port A, registered read port B.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (vram_cea) ram[vram_ada] <= vram_din;
        if (vram_ceb) vram_dout <= ram[vram_adb];
    end

    // Reference model state: what the VRAM should hold, whether a fill is in
    // progress and which address it writes next, and what read return is due.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            m_synced   = 1'b0;
    bit            m_fill     = 1'b0;
    int            m_fill_idx = 0;
    logic [DW-1:0] m_fill_val = '0;
    bit            m_done     = 1'b0;
    bit            m_disp_v   = 1'b0;
    bit            m_cpu_v    = 1'b0;
    logic [DW-1:0] m_rd_data  = '0;
    bit            m_rd_known = 1'b0;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check what the DUT shows
    // in that cycle against the model, then advance the model across the
    // rising edge.
    task automatic applyStimulus(input logic rst, input logic we,
                                 input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                                 input logic re, input logic [AW-1:0] raddr,
                                 input logic dreq, input logic [AW-1:0] daddr,
                                 input logic cs, input logic [DW-1:0] cv);
        logic          wr_en;
        logic          d_grant;
        logic          c_grant;
        logic          rd_known;
        logic          n_done;
        logic [AW-1:0] wr_a;
        logic [AW-1:0] rd_a;
        logic [DW-1:0] wr_d;
        logic [DW-1:0] rd_d;

        reset     = rst;
        cpu_we    = we;
        cpu_waddr = waddr;
        cpu_wdata = wdata;
        cpu_re    = re;
        cpu_raddr = raddr;
        disp_req  = dreq;
        disp_addr = daddr;
        clr_start = cs;
        clr_value = cv;
        #1;

        wr_en   = !rst && (m_fill || we);
        wr_a    = m_fill ? AW'(m_fill_idx) : waddr;
        wr_d    = m_fill ? m_fill_val : wdata;
        d_grant = !rst && dreq;
        c_grant = !rst && !dreq && re;
        rd_a    = dreq ? daddr : raddr;
        rd_d    = m_mem[rd_a];
        rd_known = m_known[rd_a] && !(wr_en && (wr_a == rd_a));
        n_done  = !rst && m_fill && (m_fill_idx == LAST);

        checkOutput("cpu_wready", cpu_wready, !rst && !m_fill);
        checkOutput("cpu_rready", cpu_rready, !rst && !dreq);
        checkOutput("vram_cea", vram_cea, wr_en);
        checkOutput("vram_ceb", vram_ceb, d_grant || c_grant);
        checkOutput("vram_oce", vram_oce, 1'b1);
        if (wr_en) begin
            checkOutput("vram_ada", vram_ada, wr_a);
            checkOutput("vram_din", vram_din, wr_d);
        end
        if (d_grant || c_grant) checkOutput("vram_adb", vram_adb, rd_a);
        if (m_synced) begin
            checkOutput("clr_busy", clr_busy, m_fill);
            checkOutput("clr_done", clr_done, m_done);
            checkOutput("disp_rvalid", disp_rvalid, m_disp_v);
            checkOutput("cpu_rvalid", cpu_rvalid, m_cpu_v);
            if (m_disp_v && m_rd_known) checkOutput("disp_rdata", disp_rdata, m_rd_data);
            if (m_cpu_v && m_rd_known) checkOutput("cpu_rdata", cpu_rdata, m_rd_data);
        end

        @(posedge clk);
        if (wr_en) begin
            m_mem[wr_a]   = wr_d;
            m_known[wr_a] = 1'b1;
        end
        m_disp_v   = d_grant;
        m_cpu_v    = c_grant;
        m_rd_data  = rd_d;
        m_rd_known = rd_known;
        m_done     = n_done;
        if (rst) begin
            m_synced   = 1'b1;
            m_fill     = 1'b0;
            m_fill_idx = 0;
        end else if (m_fill) begin
            if (m_fill_idx == LAST) m_fill = 1'b0;
            else m_fill_idx++;
        end else if (cs) begin
            m_fill     = 1'b1;
            m_fill_idx = 0;
            m_fill_val = cv;
        end
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic cpuWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(1'b0, 1'b1, a, d, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    // Issue an uncontended CPU read and check the returned byte against a
    // fixed expected value in the following cycle.
    task automatic cpuRead(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, a, 1'b0, '0, 1'b0, '0);
        checkOutput({tag, "_valid"}, cpu_rvalid, 1'b1);
        checkOutput(tag, cpu_rdata, exp);
    endtask

    // Run an already started fill to completion with an optional CPU write
    // held pending; reports how many busy cycles and done pulses were seen.
    task automatic runFill(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int busy_cycles, output int done_pulses);
        busy_cycles = 0;
        done_pulses = 0;
        for (int i = 0; i < 2000 && clr_busy; i++) begin
            busy_cycles++;
            applyStimulus(1'b0, we, a, d, 1'b0, '0, 1'b0, '0, 1'b0, '0);
            if (clr_done) done_pulses++;
        end
    endtask

    initial begin
        int busy_cycles;
        int done_pulses;
        int disp_pulses;
        int disp_run;
        logic          r_we;
        logic          r_re;
        logic          r_dreq;
        logic          r_cs;
        logic          r_rst;
        logic [AW-1:0] r_wa;
        logic [AW-1:0] r_ra;
        logic [AW-1:0] r_da;

        reset = 1'b1;
        cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        cpu_re = 1'b0; cpu_raddr = '0;
        disp_req = 1'b0; disp_addr = '0;
        clr_start = 1'b0; clr_value = '0;
        @(negedge clk);

        // Reset, then store and load back a byte.
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        checkOutput("reset_busy", clr_busy, 1'b0);
        checkOutput("reset_rvalid", cpu_rvalid, 1'b0);
        cpuWrite(10'h005, 8'h41);
        cpuRead(10'h005, 8'h41, "rd005");

        // Display holds the read port for three cycles while the CPU waits.
        disp_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 10'h005, 1'b1, AW'(100 + i), 1'b0, '0);
            if (disp_rvalid) disp_pulses++;
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 10'h005, 1'b0, '0, 1'b0, '0);
        checkOutput("blocked_cpu_rvalid", cpu_rvalid, 1'b1);
        checkOutput("blocked_cpu_rdata", cpu_rdata, 8'h41);
        checkOutput("disp_pulse_count", disp_pulses, 3);

        // Fill with 0x20 while a CPU store stays pending throughout.
        cpuWrite(10'h3FC, 8'h7E);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 8'h20);
        runFill(1'b1, 10'h3FD, 8'h99, busy_cycles, done_pulses);
        checkOutput("fill_busy_cycles", busy_cycles, LAST + 1);
        checkOutput("fill_done_at_end", clr_done, 1'b1);
        cpuWrite(10'h3FD, 8'h99);
        checkOutput("fill_done_pulses", done_pulses, 1);
        checkOutput("done_cleared", clr_done, 1'b0);
        cpuRead(10'h000, 8'h20, "fill_first");
        cpuRead(10'h3FB, 8'h20, "fill_last");
        cpuRead(10'h3FC, 8'h7E, "fill_beyond");
        cpuRead(10'h3FD, 8'h99, "held_write");

        // Start and store in the same cycle, store above the text area.
        applyStimulus(1'b0, 1'b1, 10'h3FF, 8'h55, 1'b0, '0, 1'b0, '0, 1'b1, 8'h33);
        runFill(1'b0, '0, '0, busy_cycles, done_pulses);
        checkOutput("fill2_done_pulses", done_pulses, 1);
        idleCycle();
        cpuRead(10'h3FF, 8'h55, "same_cycle_write");
        cpuRead(10'h1F4, 8'h33, "fill2_mid");

        // Reset partway through a fill.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 8'hA5);
        for (int i = 0; i < 500; i++) idleCycle();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        checkOutput("abort_busy", clr_busy, 1'b0);
        checkOutput("abort_done", clr_done, 1'b0);
        idleCycle();
        cpuRead(10'h000, 8'hA5, "abort_first");
        cpuRead(10'h1F3, 8'hA5, "abort_499");
        cpuRead(10'h1F4, 8'h33, "abort_500");

        // Randomised traffic checked against the model.
        disp_run = 0;
        for (int i = 0; i < 4000; i++) begin
            r_rst  = ($urandom_range(0, 999) == 0);
            r_we   = ($urandom_range(0, 1) == 0);
            r_re   = ($urandom_range(0, 1) == 0);
            r_cs   = ($urandom_range(0, 599) == 0);
            r_dreq = (disp_run < 8) && ($urandom_range(0, 2) == 0);
            disp_run = r_dreq ? disp_run + 1 : 0;
            r_wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1010, 1023)) : AW'($urandom_range(0, 15));
            r_ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1010, 1023)) : AW'($urandom_range(0, 15));
            r_da = AW'($urandom_range(0, 15));
            applyStimulus(r_rst, r_we, r_wa, DW'($urandom), r_re, r_ra,
                          r_dreq, r_da, r_cs, DW'($urandom));
        end
        idleCycle();
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
